huff_enc_ctrl: RTL

//  Sequencer for the parallel Huffman encoder datapath. Loads the codebook one

---
 rtl/huff_enc_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/huff_enc_ctrl.sv
// huff_enc_ctrl: codebook loader and symbol-stream sequencer for the parallel Huffman encoder
module huff_enc_ctrl #(
    parameter int SYMBOL_WIDTH      = 4,
    parameter int ENC_MAX_WIDTH     = 4,
    parameter int ENC_MAX_LEN_WIDTH = 2,
    parameter int NUM_SYMBOLS       = 16,
    parameter int PARALLELIZATION   = 4,
    parameter int ENC_LATENCY       = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start_config,
    input  logic                                    cb_valid,
    output logic                                    cb_ready,
    input  logic [ENC_MAX_WIDTH-1:0]                cb_enc,
    input  logic [ENC_MAX_LEN_WIDTH-1:0]            cb_len,
    input  logic                                    sym_valid,
    output logic                                    sym_ready,
    input  logic [SYMBOL_WIDTH*PARALLELIZATION-1:0] sym_data,
    output logic                                    config_en,
    output logic [NUM_SYMBOLS-1:0]                  config_select,
    output logic [ENC_MAX_WIDTH-1:0]                config_enc,
    output logic [ENC_MAX_LEN_WIDTH-1:0]            config_enc_len,
    output logic [SYMBOL_WIDTH*PARALLELIZATION-1:0] enc_symbols,
    output logic                                    enc_valid,
    output logic                                    cfg_loaded,
    output logic                                    busy
);
    localparam int IW = $clog2(NUM_SYMBOLS);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t               state;
    logic [IW-1:0]        idx;
    logic [ENC_LATENCY:0] pipe;
    logic                 cb_hs, sym_hs;
    assign cb_ready  = state == LOAD;
    assign sym_ready = state == RUN && !start_config && !config_en;
    assign cb_hs     = cb_valid && cb_ready;
    assign sym_hs    = sym_valid && sym_ready;
    assign enc_valid = pipe[ENC_LATENCY];
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            pipe           <= '0;
            config_en      <= 1'b0;
            config_select  <= '0;
            config_enc     <= '0;
            config_enc_len <= '0;
            enc_symbols    <= '0;
            cfg_loaded     <= 1'b0;
        end else begin
            config_en     <= cb_hs;
            config_select <= cb_hs ? NUM_SYMBOLS'(1) << idx : '0;
            pipe          <= {pipe[ENC_LATENCY-1:0], sym_hs};
            if (cb_hs) begin
                config_enc     <= cb_enc;
                config_enc_len <= cb_len;
            end
            if (sym_hs)
                enc_symbols <= sym_data;
            case (state)
                IDLE: if (start_config) begin
                    state      <= LOAD;
                    idx        <= '0;
                    cfg_loaded <= 1'b0;
                end
                LOAD: if (cb_hs) begin
                    if (idx == IW'(NUM_SYMBOLS - 1)) begin
                        state      <= RUN;
                        cfg_loaded <= 1'b1;
                    end else
                        idx <= idx + 1'b1;
                end
                RUN: if (start_config)
                    state <= DRAIN;
                // reload only once every accepted word has produced its enc_valid
                DRAIN: if (pipe == '0) begin
                    state      <= LOAD;
                    idx        <= '0;
                    cfg_loaded <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
